// File: rtl/parking_pkg.sv
// ============================================================================
// Module      : parking_pkg
// Description : Shared types and constants for the car-park gate subsystem.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package parking_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2
    } gate_state_e;

    localparam int unsigned C_DEF_CAPACITY = 10;
    localparam int unsigned C_DEF_CNT_W    = 4;

    // Lane front-end passwords (consumed by the per-lane sensor blocks).
    localparam logic [3:0] C_PASSWORD_ENTRY = 4'hA;
    localparam logic [3:0] C_PASSWORD_EXIT  = 4'h5;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : parking_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : N-way round-robin arbiter; search starts at ptr, one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = PTR_W'((int'(ptr) + i) % int'(N));
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PTR_W'((int'(idx) + 1) % int'(N));
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
// ============================================================================
// Module      : parking_gate_arbiter
// Description : Boom-gate arbiter and occupancy counter for the car park.
//               Optional grant timeout enabled by macro PARK_GATE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int unsigned N_ENTRY  = 2,
    parameter int unsigned CAPACITY = C_DEF_CAPACITY,
    parameter int unsigned CNT_W    = C_DEF_CNT_W,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_ENTRY-1:0] entry_req,
    input  logic               exit_req,
    input  logic               pass_done,
    output logic [N_ENTRY-1:0] entry_grant,
    output logic               exit_grant,
    output logic               gate_open,
    output logic [CNT_W-1:0]   occupancy,
    output logic               full,
    output logic               empty,
    output logic               timeout_pulse,
    output logic               GREENLED,
    output logic               REDLED
);

    localparam int unsigned C_PTR_W = ptr_width(N_ENTRY);

    if ((CAPACITY >= (2 ** CNT_W)) || (TIMEOUT < 1)) begin : g_param_check
        $error("parking_gate_arbiter: invalid CAPACITY/CNT_W/TIMEOUT");
    end

    gate_state_e        state_q, state_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [C_PTR_W-1:0] ptr_q, ptr_d;
    logic [N_ENTRY-1:0] entry_grant_q, entry_grant_d;
    logic               exit_grant_q, exit_grant_d;
    logic [N_ENTRY-1:0] entry_elig;
    logic               exit_elig;
    logic [N_ENTRY-1:0] rr_grant;
    logic [C_PTR_W-1:0] rr_next_ptr;
    logic               expired;

    assign full       = (occ_q == CNT_W'(CAPACITY));
    assign empty      = (occ_q == '0);
    assign entry_elig = full ? '0 : entry_req;
    assign exit_elig  = exit_req & ~empty;

    rr_arbiter #(
        .N     (N_ENTRY),
        .PTR_W (C_PTR_W)
    ) u_rr_arbiter (
        .req      (entry_elig),
        .ptr      (ptr_q),
        .grant    (rr_grant),
        .next_ptr (rr_next_ptr)
    );

`ifdef PARK_GATE_TIMEOUT_EN
    localparam int unsigned C_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [C_TMR_W-1:0] tmr_q, tmr_d;
    logic               timeout_pulse_q, timeout_pulse_d;

    // Timer counts OPEN cycles from 0; expiry on the TIMEOUT-th OPEN cycle.
    assign expired = (state_q == OPEN) && (tmr_q == C_TMR_W'(TIMEOUT - 1));

    always_comb begin
        tmr_d           = '0;
        timeout_pulse_d = 1'b0;
        if (state_q == OPEN) begin
            tmr_d           = tmr_q + C_TMR_W'(1);
            timeout_pulse_d = expired && !pass_done;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmr_q           <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            tmr_q           <= tmr_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign timeout_pulse = timeout_pulse_q;
`else
    assign expired       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        occ_d         = occ_q;
        ptr_d         = ptr_q;
        entry_grant_d = '0;
        exit_grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Exit has fixed priority; the RR pointer only moves on an entry win.
                if (exit_elig) begin
                    state_d      = OPEN;
                    exit_grant_d = 1'b1;
                end else if (|entry_elig) begin
                    state_d       = OPEN;
                    entry_grant_d = rr_grant;
                    ptr_d         = rr_next_ptr;
                end
            end
            OPEN: begin
                if (pass_done) begin
                    state_d = CLOSE;
                    if (exit_grant_q) begin
                        if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
                    end else if (occ_q != CNT_W'(CAPACITY)) begin
                        occ_d = occ_q + CNT_W'(1);
                    end
                end else if (expired) begin
                    state_d = CLOSE;
                end else begin
                    entry_grant_d = entry_grant_q;
                    exit_grant_d  = exit_grant_q;
                end
            end
            CLOSE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            occ_q         <= '0;
            ptr_q         <= '0;
            entry_grant_q <= '0;
            exit_grant_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            ptr_q         <= ptr_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
        end
    end

    assign entry_grant = entry_grant_q;
    assign exit_grant  = exit_grant_q;
    assign gate_open   = (state_q == OPEN);
    assign occupancy   = occ_q;
    assign GREENLED    = gate_open;
    assign REDLED      = full;

endmodule : parking_gate_arbiter

`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
// ============================================================================
// Module      : tb_parking_gate_arbiter
// Description : Directed self-checking bench for parking_gate_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_gate_arbiter;

`ifdef PARK_GATE_TIMEOUT_EN
    localparam int unsigned C_TIMEOUT = 4;
`else
    localparam int unsigned C_TIMEOUT = 255;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] entry_req;
    logic       exit_req;
    logic       pass_done;
    logic [1:0] entry_grant;
    logic       exit_grant;
    logic       gate_open;
    logic [3:0] occupancy;
    logic       full;
    logic       empty;
    logic       timeout_pulse;
    logic       GREENLED;
    logic       REDLED;

    int n_checks = 0;
    int n_errors = 0;
    int exp_occ  = 0;

    parking_gate_arbiter #(
        .N_ENTRY  (2),
        .CAPACITY (10),
        .CNT_W    (4),
        .TIMEOUT  (C_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .pass_done     (pass_done),
        .entry_grant   (entry_grant),
        .exit_grant    (exit_grant),
        .gate_open     (gate_open),
        .occupancy     (occupancy),
        .full          (full),
        .empty         (empty),
        .timeout_pulse (timeout_pulse),
        .GREENLED      (GREENLED),
        .REDLED        (REDLED)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One IDLE-sampled request -> grant, then a pass and the closed gap.
    task automatic serve(input string tag, input logic [1:0] exp_entry, input logic exp_exit);
        tick();
        check_eq({tag, " entry_grant"}, 32'(entry_grant), 32'(exp_entry));
        check_eq({tag, " exit_grant"}, 32'(exit_grant), 32'(exp_exit));
        check_eq({tag, " gate_open"}, 32'(gate_open), 32'd1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        exp_occ   = exp_exit ? exp_occ - 1 : exp_occ + 1;
        check_eq({tag, " occupancy"}, 32'(occupancy), 32'(exp_occ));
        check_eq({tag, " close gate"}, 32'(gate_open), 32'd0);
        check_eq({tag, " close grants"}, 32'({exit_grant, entry_grant}), 32'd0);
        tick();
        check_eq({tag, " idle gate"}, 32'(gate_open), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        entry_req = '0;
        exit_req  = 1'b0;
        pass_done = 1'b0;
        tick();
        tick();
        check_eq("rst occupancy", 32'(occupancy), 32'd0);
        check_eq("rst empty", 32'(empty), 32'd1);
        check_eq("rst full", 32'(full), 32'd0);
        check_eq("rst grants", 32'({exit_grant, entry_grant}), 32'd0);
        check_eq("rst gate", 32'(gate_open), 32'd0);
        check_eq("rst leds", 32'({GREENLED, REDLED}), 32'd0);
        check_eq("rst timeout", 32'(timeout_pulse), 32'd0);
        reset = 1'b1;
        tick();

        // Single entry; request dropped while open must not release the gate.
        entry_req = 2'b01;
        tick();
        check_eq("t1 grant", 32'(entry_grant), 32'd1);
        check_eq("t1 green", 32'(GREENLED), 32'd1);
        entry_req = 2'b00;
        tick();
        check_eq("t1 held open", 32'(gate_open), 32'd1);
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        exp_occ   = 1;
        check_eq("t1 occupancy", 32'(occupancy), 32'd1);
        check_eq("t1 green off", 32'(GREENLED), 32'd0);
        check_eq("t1 empty", 32'(empty), 32'd0);
        tick();

        // Pointer sits at lane 1 after lane 0 won.
        entry_req = 2'b11;
        serve("rr0", 2'b10, 1'b0);
        serve("rr1", 2'b01, 1'b0);
        serve("rr2", 2'b10, 1'b0);
        serve("rr3", 2'b01, 1'b0);

        entry_req = 2'b01;
        for (int i = 0; i < 5; i++) serve("fill", 2'b01, 1'b0);
        check_eq("full flag", 32'(full), 32'd1);
        check_eq("red led", 32'(REDLED), 32'd1);

        entry_req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("full no grant", 32'({exit_grant, gate_open}), 32'd0);
        end

        exit_req = 1'b1;
        serve("full exit", 2'b00, 1'b1);
        check_eq("occ after exit", 32'(occupancy), 32'd9);
        exit_req = 1'b0;
        serve("entry after exit", 2'b10, 1'b0);
        entry_req = 2'b00;

        exit_req = 1'b1;
        for (int i = 0; i < 10; i++) serve("drain", 2'b00, 1'b1);
        check_eq("empty flag", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("empty no grant", 32'({exit_grant, gate_open}), 32'd0);
        end
        exit_req  = 1'b0;
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        tick();
        check_eq("idle pass ignored", 32'(occupancy), 32'd0);

        // Pointer at 0 after lane 1 won last.
        entry_req = 2'b01;
        for (int i = 0; i < 5; i++) serve("refill", 2'b01, 1'b0);
        tick();
        check_eq("pre-rst open", 32'(gate_open), 32'd1);
        reset = 1'b0;
        tick();
        check_eq("mid rst gate", 32'(gate_open), 32'd0);
        check_eq("mid rst occ", 32'(occupancy), 32'd0);
        check_eq("mid rst grant", 32'(entry_grant), 32'd0);
        entry_req = 2'b00;
        reset     = 1'b1;
        exp_occ   = 0;
        tick();
        check_eq("post rst idle", 32'(gate_open), 32'd0);

        entry_req = 2'b01;
        tick();
        check_eq("to grant", 32'(entry_grant), 32'd1);
        entry_req = 2'b00;
`ifdef PARK_GATE_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("to still open", 32'(gate_open), 32'd1);
        end
        tick();
        check_eq("to expired gate", 32'(gate_open), 32'd0);
        check_eq("to pulse", 32'(timeout_pulse), 32'd1);
        check_eq("to occ kept", 32'(occupancy), 32'd0);
        tick();
        check_eq("to pulse width", 32'(timeout_pulse), 32'd0);
        entry_req = 2'b01;
        tick();
        check_eq("to2 grant", 32'(gate_open), 32'd1);
        entry_req = 2'b00;
        for (int i = 0; i < 3; i++) tick();
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_eq("to2 gate", 32'(gate_open), 32'd0);
        check_eq("to2 no pulse", 32'(timeout_pulse), 32'd0);
        check_eq("to2 occ", 32'(occupancy), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("no-to open", 32'({timeout_pulse, gate_open}), 32'd1);
        end
        pass_done = 1'b1;
        tick();
        pass_done = 1'b0;
        check_eq("no-to occ", 32'(occupancy), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_parking_gate_arbiter

`default_nettype wire

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the car park's single boom gate between several entry lanes and one exit lane, and owns the occupancy count for the lot. It arbitrates pending requests and holds the gate open for exactly one vehicle per grant. It updates occupancy on completed passes and drives the lot's GREENLED/REDLED indicators. It sits between the per-lane sensor/password front ends, which raise requests, and the gate actuator.

## Interface
Parameters:
- N_ENTRY, 2: number of entry lanes (≥1).
- CAPACITY, 10: number of slots in the lot.
- CNT_W, 4: occupancy width; must satisfy 2^CNT_W > CAPACITY.
- TIMEOUT, 255: maximum cycles the gate is held open per grant (used only when the timeout feature is compiled in).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset.
- entry_req  in  N_ENTRY  per-lane level request; held until granted.
- exit_req  in  1  exit lane level request.
- pass_done  in  1  one-cycle pulse: the vehicle has cleared the gate (back sensor).
- entry_grant  out  N_ENTRY  one-hot; the granted entry lane.
- exit_grant  out  1  the exit lane is granted.
- gate_open  out  1  gate actuator command.
- occupancy  out  CNT_W  cars currently in the lot.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.
- timeout_pulse  out  1  one-cycle pulse when a grant times out.
- GREENLED  out  1  equals gate_open.
- REDLED  out  1  equals full.

## Operation
- FSM states: IDLE, OPEN, CLOSE.
- IDLE:
  - An entry request is eligible only when !full. The exit request is eligible only when !empty.
  - If any eligible request is present, go to OPEN, latch the winner and assert its grant.
  - The exit lane has fixed priority over all entry lanes.
  - Entry lanes use round-robin. The pointer advances to the lane after the winner; it does not move when exit wins or nothing is granted.
- OPEN:
  - gate_open = 1 and the latched grant is held.
  - The granted requester dropping its req does not release the gate.
  - On pass_done: an entry grant increments occupancy, an exit grant decrements it. Then go to CLOSE.
- CLOSE:
  - One cycle with all grants and gate_open at 0, then IDLE.
  - This guarantees at least one closed cycle between consecutive grants.
- pass_done outside OPEN is ignored; occupancy does not change.
- Occupancy saturates at 0 and CAPACITY. The eligibility rules make both unreachable in normal operation; saturation is a safety net only.
- full and empty are combinational from the occupancy register.

## Timing
- Reset values: state IDLE, occupancy 0, RR pointer 0, all grants 0, gate_open 0, timeout_pulse 0. Therefore empty = 1, full = 0, GREENLED = 0, REDLED = 0.
- A request sampled in IDLE at edge k produces its grant and gate_open at edge k+1 (one-cycle latency).
- pass_done sampled at edge m updates occupancy at edge m+1; the same edge enters CLOSE and deasserts grant and gate_open.
- Earliest next grant is at edge m+3 (CLOSE at m+1, IDLE at m+2, grant at m+3).
- Eligibility in IDLE uses the registered occupancy, which already reflects the previous pass.
- Reset asserted mid-OPEN: the gate closes at the next edge and occupancy clears to 0. Software re-syncs occupancy after a reset.
- Simultaneous exit_req and entry_req in IDLE with the lot full: exit is granted. The entry lane is served after the following CLOSE.

## Configuration
- Macro: PARK_GATE_TIMEOUT_EN.
- Defined:
  - A counter runs in OPEN.
  - If pass_done has not arrived after TIMEOUT cycles in OPEN, go to CLOSE without changing occupancy and pulse timeout_pulse for one cycle.
  - pass_done on the same cycle as expiry wins: the count is updated and there is no timeout pulse.
- Not defined: OPEN waits indefinitely for pass_done, and timeout_pulse is tied to 0.

## Structure
- Shared package parking_pkg:
  - state enum (IDLE, OPEN, CLOSE);
  - default CAPACITY and CNT_W constants;
  - password constants used by the lane front ends.
- Sub-module rr_arbiter (N-way round-robin):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, next pointer.
- The FSM, occupancy counter and timeout counter stay in the top module.

## Test plan
- Reset, then entry_req[0] = 1 → entry_grant = 01 and gate_open = 1 one cycle later. pass_done → occupancy = 1, GREENLED = 0 at the next edge.
- Both entry lanes requesting continuously, with pass_done after each grant → grants alternate 01, 10, 01, 10, with exactly one CLOSE cycle between them.
- Fill the lot to 10 → full = 1, REDLED = 1, entry requests never granted. Then exit_req → exit_grant; after pass_done, occupancy = 9 and the entry lane is granted next.
- exit_req with occupancy 0 → no grant. pass_done pulsed in IDLE → occupancy unchanged.
- PARK_GATE_TIMEOUT_EN with TIMEOUT = 4, grant and no pass_done → timeout_pulse after 4 OPEN cycles and occupancy unchanged. Repeat with pass_done on the expiry cycle → count updated, no pulse.
- reset = 0 during OPEN with occupancy 5 → next edge: gate_open = 0, occupancy = 0, state IDLE.
